// File: rtl/io_bus_master.sv
// io_bus_master: CPU-side initiator for the 8-bit memory-mapped IO bus.
// Turns a one-cycle request into a timed SETUP / STROBE / HOLD bus cycle and
// reports completion with a one-cycle o_done pulse (read data on o_rdata).
//
// Optional feature macro: IO_WAIT_EN (adds i_ioWaitN / o_timeout; peripheral
// may stretch STROBE, bounded by WAIT_TIMEOUT stretched cycles).
//
// Ports:
//   i_clk, i_resetn          clock, async active-low reset
//   i_req/i_write/i_addr/i_wdata  request, sampled only in IDLE
//   o_busy, o_done, o_rdata  status / completion / read data
//   o_ioSelect, o_ioAddress  peripheral select and address
//   o_ioNOE, o_ioNWE         active-low read / write strobes
//   o_bus, o_busNOE          write data and its active-low bus enable
//   i_bus                    shared data bus (read data)
//   i_ioWaitN, o_timeout     IO_WAIT_EN only
//
// All outputs are registered from the next state, so they line up with the
// FSM state they describe. The done cycle is an IDLE cycle that can accept
// the next request, so back-to-back transfers repeat every
// SETUP+STROBE+HOLD+1 cycles.
module io_bus_master #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int WAIT_TIMEOUT  = 255
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_req,
  input  logic       i_write,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_ioSelect,
  output logic [7:0] o_ioAddress,
  output logic       o_ioNOE,
  output logic       o_ioNWE,
  output logic [7:0] o_bus,
  output logic       o_busNOE,
`ifdef IO_WAIT_EN
  input  logic       i_ioWaitN,
  output logic       o_timeout,
`endif
  input  logic [7:0] i_bus
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 || STROBE_CYCLES < 1 ||
      STROBE_CYCLES > 15 || HOLD_CYCLES < 1 || HOLD_CYCLES > 15 ||
      WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 255) begin : g_bad_params
    $error("io_bus_master: timing parameter out of range");
  end

  // Counters are reloaded with (length-1) and the phase ends when they hit 0.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  logic       wr_q;
  logic       accept, leave_strobe, wr_nx;

`ifdef IO_WAIT_EN
  localparam logic [7:0] WAIT_MAX = 8'(WAIT_TIMEOUT);
  logic [7:0] wait_q, wait_n;
  logic       abort;
`endif

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef IO_WAIT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
`ifdef IO_WAIT_EN
      wait_q  <= wait_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    accept  = 1'b0;
`ifdef IO_WAIT_EN
    wait_n  = wait_q;
`endif
    case (state_q)
      IDLE:
        if (i_req) begin
          accept  = 1'b1;
          state_n = SETUP;
          cnt_n   = SETUP_LD;
        end
      SETUP:
        if (cnt_q != 4'd0) cnt_n = cnt_q - 4'd1;
        else begin
          state_n = STROBE;
          cnt_n   = STROBE_LD;
`ifdef IO_WAIT_EN
          wait_n  = '0;
`endif
        end
      STROBE:
        if (cnt_q != 4'd0) cnt_n = cnt_q - 4'd1;
`ifdef IO_WAIT_EN
        // Stretch only once the nominal strobe has elapsed; abort when the
        // stretch budget is used up.
        else if (!i_ioWaitN && wait_q != WAIT_MAX) wait_n = wait_q + 8'd1;
`endif
        else begin
          state_n = HOLD;
          cnt_n   = HOLD_LD;
        end
      HOLD:
        if (cnt_q != 4'd0) cnt_n = cnt_q - 4'd1;
        else state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign leave_strobe = (state_q == STROBE) && (state_n == HOLD);
  assign wr_nx        = accept ? i_write : wr_q;
`ifdef IO_WAIT_EN
  assign abort        = leave_strobe && !i_ioWaitN;
`endif

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      wr_q        <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_rdata     <= '0;
      o_ioSelect  <= 1'b0;
      o_ioAddress <= '0;
      o_ioNOE     <= 1'b1;
      o_ioNWE     <= 1'b1;
      o_bus       <= '0;
      o_busNOE    <= 1'b1;
`ifdef IO_WAIT_EN
      o_timeout   <= 1'b0;
`endif
    end else begin
      wr_q       <= wr_nx;
      o_busy     <= (state_n != IDLE);
      o_done     <= (state_q == HOLD) && (state_n == IDLE);
      o_ioSelect <= (state_n != IDLE);
      if (accept)                o_ioAddress <= i_addr;
      else if (state_n == IDLE)  o_ioAddress <= '0;
      if (accept && i_write)     o_bus <= i_wdata;
      o_busNOE   <= !((state_n != IDLE) && wr_nx);
      o_ioNOE    <= !((state_n == STROBE) && !wr_nx);
      o_ioNWE    <= !((state_n == STROBE) && wr_nx);
`ifdef IO_WAIT_EN
      o_timeout  <= abort;
      if (leave_strobe && !wr_q) o_rdata <= abort ? 8'hFF : i_bus;
`else
      if (leave_strobe && !wr_q) o_rdata <= i_bus;
`endif
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Scoreboard bench for io_bus_master: stimulus pushes the expected outcome of
// each transfer, a monitor observes the bus cycle and checks on o_done.
module tb_io_bus_master;
  localparam int S = 1, ST = 2, H = 1, SUM = S + ST + H;
  localparam int P2 = 3 + 1 + 2 + 1;  // second instance: 3/1/2 plus done cycle

  logic       i_clk = 1'b0, i_resetn = 1'b0;
  logic       i_req = 1'b0, i_write = 1'b0;
  logic [7:0] i_addr = '0, i_wdata = '0, i_bus = '0;
  logic       i_ioWaitN = 1'b1;
  logic       o_busy, o_done, o_ioSelect, o_ioNOE, o_ioNWE, o_busNOE;
  logic [7:0] o_rdata, o_ioAddress, o_bus;
  logic       b_req = 1'b0;
  logic       b_busy, b_done, b_ioSelect, b_ioNOE, b_ioNWE, b_busNOE;
  logic [7:0] b_rdata, b_ioAddress, b_bus;
`ifdef IO_WAIT_EN
  logic       o_timeout, b_timeout;
`endif

  io_bus_master #(.SETUP_CYCLES(S), .STROBE_CYCLES(ST), .HOLD_CYCLES(H),
                  .WAIT_TIMEOUT(8)) u_dut (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_req(i_req), .i_write(i_write),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done),
    .o_rdata(o_rdata), .o_ioSelect(o_ioSelect), .o_ioAddress(o_ioAddress),
    .o_ioNOE(o_ioNOE), .o_ioNWE(o_ioNWE), .o_bus(o_bus), .o_busNOE(o_busNOE),
`ifdef IO_WAIT_EN
    .i_ioWaitN(i_ioWaitN), .o_timeout(o_timeout),
`endif
    .i_bus(i_bus));

  io_bus_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2)) u_dut2 (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_req(b_req), .i_write(1'b0),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(b_busy), .o_done(b_done),
    .o_rdata(b_rdata), .o_ioSelect(b_ioSelect), .o_ioAddress(b_ioAddress),
    .o_ioNOE(b_ioNOE), .o_ioNWE(b_ioNWE), .o_bus(b_bus), .o_busNOE(b_busNOE),
`ifdef IO_WAIT_EN
    .i_ioWaitN(1'b1), .o_timeout(b_timeout),
`endif
    .i_bus(i_bus));

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         issue;
    int         waits;
    logic       tmo;
  } exp_t;

  exp_t       sb[$];
  int         d2[$];
  int         cyc = 0;
  int         checks = 0, failures = 0;
  logic [7:0] m_rdata = '0;  // model of the read-data register

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  initial forever begin @(posedge i_clk); cyc++; end
  initial forever begin @(negedge i_clk); if (b_done) d2.push_back(cyc); end

  // Monitor: accumulate what the bus did during the transfer, judge at o_done.
  initial begin
    int pos, stb_cnt, stb_first, bnoe_cnt, perr;
    exp_t e;
    pos = 0; stb_cnt = 0; stb_first = 0; bnoe_cnt = 0; perr = 0;
    forever begin
      @(negedge i_clk);
      if (!i_resetn) begin
        pos = 0; stb_cnt = 0; stb_first = 0; bnoe_cnt = 0; perr = 0;
      end else begin
        if (o_busy) pos++;
        if (!o_ioNOE && !o_ioNWE) perr++;
        if (o_ioSelect !== o_busy) perr++;
        if (!o_busy && (o_ioAddress !== 8'h00 || !o_ioNOE || !o_ioNWE || !o_busNOE)) perr++;
        if (o_busy && sb.size() > 0) begin
          if (o_ioAddress !== sb[0].addr) perr++;
          if (!o_busNOE && o_bus !== sb[0].wdata) perr++;
          if (sb[0].wr ? !o_ioNOE : !o_ioNWE) perr++;
        end
        if (!o_ioNOE || !o_ioNWE) begin
          stb_cnt++;
          if (stb_first == 0) stb_first = pos;
        end
        if (!o_busNOE) bnoe_cnt++;
        if (o_done) begin
          if (sb.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = sb.pop_front();
            chk("done_latency", cyc, e.issue + SUM + e.waits);
            chk("strobe_len", stb_cnt, ST + e.waits);
            chk("strobe_pos", stb_first, S + 1);
            chk("busnoe_len", bnoe_cnt, e.wr ? SUM + e.waits : 0);
            chk("rdata", o_rdata, e.rdata);
            chk("protocol", perr, 0);
`ifdef IO_WAIT_EN
            chk("timeout_flag", o_timeout, e.tmo);
`endif
          end
          pos = 0; stb_cnt = 0; stb_first = 0; bnoe_cnt = 0; perr = 0;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_rdata"}, o_rdata, 0);
    chk({tag, "_sel"}, o_ioSelect, 0);
    chk({tag, "_addr"}, o_ioAddress, 0);
    chk({tag, "_noe"}, o_ioNOE, 1);
    chk({tag, "_nwe"}, o_ioNWE, 1);
    chk({tag, "_bus"}, o_bus, 0);
    chk({tag, "_busnoe"}, o_busNOE, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 200) begin @(negedge i_clk); n++; end
    if (o_busy) chk("idle_wait_expired", 1, 0);
  endtask

  // Issue one transfer at the current negedge (DUT idle) and queue its outcome.
  task automatic do_xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] bv, input int w, input logic tmo, input bit poke);
    exp_t e;
    int n;
    wait_idle();
    i_req = 1'b1; i_write = wr; i_addr = a; i_wdata = d; i_bus = bv;
    i_ioWaitN = (w == 0 && !tmo);
    if (!wr) m_rdata = tmo ? 8'hFF : bv;
    e.wr = wr; e.addr = a; e.wdata = d; e.rdata = m_rdata;
    e.issue = cyc + 1; e.waits = w; e.tmo = tmo;
    sb.push_back(e);
    @(negedge i_clk);
    i_req = 1'b0; i_addr = 8'($urandom); i_wdata = 8'($urandom); i_write = 1'($urandom);
    if (w != 0 || tmo) begin
      n = 0;
      while (!(tmo ? o_done : (cyc == e.issue + S + ST - 1 + w)) && n < 400) begin
        @(negedge i_clk); n++;
      end
      i_ioWaitN = 1'b1;
    end
    if (poke) begin
      @(negedge i_clk);
      if (o_busy) begin
        i_req = 1'b1;
        @(negedge i_clk);
        i_req = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n, n_acc;
    repeat (3) @(negedge i_clk);
    check_reset_vals("reset");
    i_resetn = 1'b1;
    @(negedge i_clk);

    // Directed: write A5 to 0x00, read 3C, then a write must keep rdata.
    do_xfer(1'b1, 8'h00, 8'hA5, 8'h00, 0, 1'b0, 1'b0);
    do_xfer(1'b0, 8'h00, 8'h00, 8'h3C, 0, 1'b0, 1'b0);
    do_xfer(1'b1, 8'h11, 8'h5A, 8'hC3, 0, 1'b0, 1'b0);

    // Random traffic, some with a dropped request poked in while busy.
    for (int i = 0; i < 30; i++)
      do_xfer(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 1'b0,
              1'($urandom_range(0, 1)));

    // i_req held high: accepted in every done cycle.
    wait_idle();
    i_req = 1'b1; i_write = 1'b1; i_addr = 8'h42; i_wdata = 8'h99;
    for (int j = 0; j < 3; j++) begin
      exp_t e;
      e.wr = 1'b1; e.addr = 8'h42; e.wdata = 8'h99; e.rdata = m_rdata;
      e.issue = cyc + 1 + j * (SUM + 1); e.waits = 0; e.tmo = 1'b0;
      sb.push_back(e);
    end
    repeat (2 * (SUM + 1) + 1) @(negedge i_clk);
    i_req = 1'b0;

    // Reset in the middle of a write strobe.
    wait_idle();
    i_req = 1'b1; i_write = 1'b1; i_addr = 8'h5A; i_wdata = 8'h77;
    @(negedge i_clk);
    i_req = 1'b0;
    n = 0;
    while (o_ioNWE && n < 20) begin @(negedge i_clk); n++; end
    chk("reached_write_strobe", o_ioNWE, 0);
    i_resetn = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (2) @(negedge i_clk);
    m_rdata = 8'h00;
    i_resetn = 1'b1;
    @(negedge i_clk);
    chk("post_reset_done", o_done, 0);
    chk("post_reset_busy", o_busy, 0);
    do_xfer(1'b0, 8'h80, 8'h00, 8'hE7, 0, 1'b0, 1'b0);
    do_xfer(1'b1, 8'hFF, 8'h01, 8'h00, 0, 1'b0, 1'b0);

`ifdef IO_WAIT_EN
    do_xfer(1'b0, 8'h21, 8'h00, 8'h6D, 5, 1'b0, 1'b0);
    do_xfer(1'b1, 8'h22, 8'hB4, 8'h00, 3, 1'b0, 1'b0);
    do_xfer(1'b0, 8'h23, 8'h00, 8'h12, 8, 1'b1, 1'b0);
    do_xfer(1'b1, 8'h24, 8'h3E, 8'h00, 0, 1'b0, 1'b0);
`endif

    wait_idle();
    repeat (2) @(negedge i_clk);
    chk("scoreboard_drained", sb.size(), 0);

    // Second instance (3/1/2): continuous request, fixed repetition period.
    d2.delete();
    c0 = cyc;
    b_req = 1'b1;
    repeat (30) @(negedge i_clk);
    b_req = 1'b0;
    repeat (12) @(negedge i_clk);
    n_acc = 0;
    for (int k = 0; 1 + k * P2 <= 30; k++) n_acc++;
    chk("b2b_done_count", d2.size(), n_acc);
    for (int k = 0; k < d2.size() && k < n_acc; k++)
      chk("b2b_done_time", d2[k], c0 + 1 + 6 + k * P2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
